// File: rtl/median_window_sorter.sv
`default_nettype none
// ============================================================================
//  Module   : median_window_sorter
//  Purpose  : Sorted sliding window with age tags; emits the registered median.
//             Define MEDIAN_MINMAX_EN to also register the window min and max.
//  Revision : 1.0  initial release
// ============================================================================
module median_window_sorter #(
    parameter int DW      = 8,
    parameter int WIN_MAX = 9,
    parameter int CW      = $clog2(WIN_MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [CW-1:0] win_size,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef MEDIAN_MINMAX_EN
    output logic [DW-1:0] out_median,
    output logic [DW-1:0] out_min,
    output logic [DW-1:0] out_max
`else
    output logic [DW-1:0] out_median
`endif
);

    localparam logic [1:0] c_sel_keep  = 2'd0;
    localparam logic [1:0] c_sel_left  = 2'd1;
    localparam logic [1:0] c_sel_right = 2'd2;
    localparam logic [1:0] c_sel_load  = 2'd3;

    logic [DW-1:0]      r_val [WIN_MAX];
    logic [CW-1:0]      r_age [WIN_MAX];
    logic [WIN_MAX-1:0] r_act;
    logic [CW-1:0]      r_fill;
    logic [CW-1:0]      r_win_q;

    logic [DW-1:0]      w_nval [WIN_MAX];
    logic [CW-1:0]      w_nage [WIN_MAX];
    logic [CW-1:0]      w_win_clamp;
    logic               w_accept;
    logic               w_steady;
    int                 w_p;
    int                 w_r;
    int                 w_fill;
    int                 w_win;
    int                 w_fill_nxt;
    logic [DW-1:0]      w_med;
`ifdef MEDIAN_MINMAX_EN
    logic [DW-1:0]      w_min;
    logic [DW-1:0]      w_max;
`endif

    assign in_ready = !out_valid || out_ready;
    // flush wins over a same-cycle sample, which is simply dropped
    assign w_accept = in_valid && in_ready && !flush;

    always_comb begin
        w_win_clamp = win_size;
        if (int'(win_size) > WIN_MAX) begin
            w_win_clamp = CW'(WIN_MAX);
        end else if (win_size < CW'(3)) begin
            w_win_clamp = CW'(3);
        end else if (!win_size[0]) begin
            w_win_clamp = win_size - CW'(1);
        end
    end

    // Insert position p and eviction index r; while filling, r is the first
    // free cell so the fill phase reuses the p <= r shifting rule.
    always_comb begin
        w_fill   = int'(r_fill);
        w_win    = int'(r_win_q);
        w_steady = (r_fill == r_win_q);
        w_p      = 0;
        w_r      = w_fill;
        for (int i = 0; i < WIN_MAX; i++) begin
            if (r_act[i] && (r_val[i] <= in_data)) begin
                w_p = w_p + 1;
            end
            if (w_steady && r_act[i] && (int'(r_age[i]) == w_win - 1)) begin
                w_r = i;
            end
        end
        w_fill_nxt = w_steady ? w_fill : w_fill + 1;
    end

    for (genvar gi = 0; gi < WIN_MAX; gi++) begin : g_cell
        logic [DW-1:0] w_lo_val;
        logic [DW-1:0] w_hi_val;
        logic [CW-1:0] w_lo_age;
        logic [CW-1:0] w_hi_age;
        logic [1:0]    w_sel;
        logic [DW-1:0] w_cell_val;
        logic [CW-1:0] w_cell_age;

        if (gi == 0) begin : g_lo_edge
            assign w_lo_val = '0;
            assign w_lo_age = '0;
        end else begin : g_lo_link
            assign w_lo_val = r_val[gi-1];
            assign w_lo_age = r_age[gi-1];
        end

        if (gi == WIN_MAX - 1) begin : g_hi_edge
            assign w_hi_val = '0;
            assign w_hi_age = '0;
        end else begin : g_hi_link
            assign w_hi_val = r_val[gi+1];
            assign w_hi_age = r_age[gi+1];
        end

        always_comb begin
            w_sel = c_sel_keep;
            if (w_p <= w_r) begin
                if (gi == w_p) begin
                    w_sel = c_sel_load;
                end else if ((gi > w_p) && (gi <= w_r)) begin
                    w_sel = c_sel_right;
                end
            end else begin
                if (gi == w_p - 1) begin
                    w_sel = c_sel_load;
                end else if ((gi >= w_r) && (gi < w_p - 1)) begin
                    w_sel = c_sel_left;
                end
            end

            w_cell_val = r_val[gi];
            w_cell_age = r_age[gi] + CW'(1);
            case (w_sel)
                c_sel_load: begin
                    w_cell_val = in_data;
                    w_cell_age = '0;
                end
                c_sel_right: begin
                    w_cell_val = w_lo_val;
                    w_cell_age = w_lo_age + CW'(1);
                end
                c_sel_left: begin
                    w_cell_val = w_hi_val;
                    w_cell_age = w_hi_age + CW'(1);
                end
                default: ;
            endcase
        end

        assign w_nval[gi] = w_cell_val;
        assign w_nage[gi] = w_cell_age;
    end

    always_comb begin
        w_med = '0;
`ifdef MEDIAN_MINMAX_EN
        w_min = w_nval[0];
        w_max = '0;
`endif
        for (int i = 0; i < WIN_MAX; i++) begin
            if (i == (w_win - 1) / 2) begin
                w_med = w_nval[i];
            end
`ifdef MEDIAN_MINMAX_EN
            if (i == w_win - 1) begin
                w_max = w_nval[i];
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN_MAX; i++) begin
                r_val[i] <= '0;
                r_age[i] <= '0;
            end
            r_act      <= '0;
            r_fill     <= '0;
            r_win_q    <= CW'(WIN_MAX);
            out_valid  <= 1'b0;
            out_median <= '0;
`ifdef MEDIAN_MINMAX_EN
            out_min    <= '0;
            out_max    <= '0;
`endif
        end else if (flush) begin
            for (int i = 0; i < WIN_MAX; i++) begin
                r_age[i] <= '0;
            end
            r_act     <= '0;
            r_fill    <= '0;
            r_win_q   <= w_win_clamp;
            out_valid <= 1'b0;
        end else if (w_accept) begin
            for (int i = 0; i < WIN_MAX; i++) begin
                r_val[i] <= w_nval[i];
                r_age[i] <= w_nage[i];
                r_act[i] <= (i < w_fill_nxt);
            end
            r_fill <= CW'(w_fill_nxt);
            if (w_fill_nxt == w_win) begin
                out_valid  <= 1'b1;
                out_median <= w_med;
`ifdef MEDIAN_MINMAX_EN
                out_min    <= w_min;
                out_max    <= w_max;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_median_window_sorter.sv
`default_nettype none
// Directed and randomised stimulus against a queue-based reference window;
// expected medians are queued on accept and compared on output handshake.
module tb_median_window_sorter;
    localparam int DW      = 8;
    localparam int WIN_MAX = 9;
    localparam int CW      = $clog2(WIN_MAX);

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          flush     = 1'b0;
    logic [CW-1:0] win_size  = '0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_median;
`ifdef MEDIAN_MINMAX_EN
    logic [DW-1:0] out_min;
    logic [DW-1:0] out_max;
`endif

    median_window_sorter #(.DW(DW), .WIN_MAX(WIN_MAX), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .win_size  (win_size),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef MEDIAN_MINMAX_EN
        .out_median(out_median),
        .out_min   (out_min),
        .out_max   (out_max)
`else
        .out_median(out_median)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int m_win[$];
    int m_winq   = WIN_MAX;
    int exp_med[$];
    int exp_min[$];
    int exp_max[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sorted_at(input int idx);
        int s[$];
        s = m_win;
        s.sort();
        return s[idx];
    endfunction

    function automatic int clamp_win(input int w);
        if (w > WIN_MAX) return WIN_MAX;
        if (w < 3) return 3;
        if (w % 2 == 0) return w - 1;
        return w;
    endfunction

    task automatic model_accept(input int v);
        m_win.push_back(v);
        if (m_win.size() > m_winq) void'(m_win.pop_front());
        if (m_win.size() == m_winq) begin
            exp_med.push_back(sorted_at((m_winq - 1) / 2));
            exp_min.push_back(sorted_at(0));
            exp_max.push_back(sorted_at(m_winq - 1));
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int v);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = DW'(v);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", {31'd0, in_ready}, 1);
        end else begin
            model_accept(v);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_flush(input int w, input logic iv, input int d);
        flush    = 1'b1;
        win_size = CW'(w);
        in_valid = iv;
        in_data  = DW'(d);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        m_win.delete();
        m_winq = clamp_win(w);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_med.size() == 0) begin
                chk("sb_extra_output", exp_med.size(), 1);
            end else begin
                chk("sb_median", {24'd0, out_median}, exp_med.pop_front());
`ifdef MEDIAN_MINMAX_EN
                chk("sb_min", {24'd0, out_min}, exp_min.pop_front());
                chk("sb_max", {24'd0, out_max}, exp_max.pop_front());
`else
                void'(exp_min.pop_front());
                void'(exp_max.pop_front());
`endif
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_median", {24'd0, out_median}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // window of 3
        do_flush(3, 1'b0, 0);
        send(5);
        chk("fill1_no_valid", {31'd0, out_valid}, 0);
        send(1);
        chk("fill2_no_valid", {31'd0, out_valid}, 0);
        send(9);
        chk("full_valid", {31'd0, out_valid}, 1);
        chk("med_5_1_9", {24'd0, out_median}, 5);
`ifdef MEDIAN_MINMAX_EN
        chk("min_5_1_9", {24'd0, out_min}, 1);
        chk("max_5_1_9", {24'd0, out_max}, 9);
`endif
        send(2);
        chk("med_evict5", {24'd0, out_median}, 2);
        send(2);
        chk("med_tie", {24'd0, out_median}, 2);

        // backpressure hold
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = DW'(k * 37 + 3);
            @(negedge clk);
            chk("hold_in_ready", {31'd0, in_ready}, 0);
            chk("hold_valid", {31'd0, out_valid}, 1);
            chk("hold_median", {24'd0, out_median}, 2);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_valid_drop", {31'd0, out_valid}, 0);
        send(4);
        chk("after_hold_med", {24'd0, out_median}, 2);

        // flush to even size with a same-cycle sample that must be dropped
        do_flush(4, 1'b1, 200);
        chk("flush_clears_valid", {31'd0, out_valid}, 0);
        send(10);
        send(30);
        chk("flush_sample_dropped", {31'd0, out_valid}, 0);
        send(20);
        chk("win4_as3_valid", {31'd0, out_valid}, 1);
        chk("win4_as3_med", {24'd0, out_median}, 20);

        // descending fill of 9, then an insert above the evicted maximum
        do_flush(9, 1'b0, 0);
        for (int k = 9; k >= 1; k--) send(k * 10);
        chk("desc_valid", {31'd0, out_valid}, 1);
        chk("desc_med", {24'd0, out_median}, 50);
        send(100);
        chk("p_gt_r_med", {24'd0, out_median}, 50);
`ifdef MEDIAN_MINMAX_EN
        chk("p_gt_r_min", {24'd0, out_min}, 10);
        chk("p_gt_r_max", {24'd0, out_max}, 100);
`endif

        // asynchronous reset with a partial window
        do_flush(9, 1'b0, 0);
        send(11); send(22); send(33); send(44);
        chk("partial_no_valid", {31'd0, out_valid}, 0);
        chk("median_before_rst", {24'd0, out_median}, 50);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 0);
        chk("async_rst_median", {24'd0, out_median}, 0);
        m_win.delete();
        m_winq = WIN_MAX;
        exp_med.delete();
        exp_min.delete();
        exp_max.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) send($urandom_range(0, 255));
        chk("post_rst_8_no_valid", {31'd0, out_valid}, 0);
        send($urandom_range(0, 255));
        chk("post_rst_9_valid", {31'd0, out_valid}, 1);
        for (int k = 0; k < 20; k++) send($urandom_range(0, 255));

        // clamping of oversized and undersized requests, random traffic
        do_flush(15, 1'b0, 0);
        for (int k = 0; k < 14; k++) send($urandom_range(0, 255));
        do_flush(0, 1'b0, 0);
        for (int k = 0; k < 8; k++) send($urandom_range(0, 15));
        do_flush(6, 1'b0, 0);
        for (int k = 0; k < 12; k++) send($urandom_range(0, 255));

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drain", exp_med.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
